// File: rtl/flop_stim_checker.sv
// Drives a reset-then-count stimulus into an external flip-flop and checks its qout two cycles later.
// All outputs registered; start is only honoured in IDLE, and no backpressure is applied to the DUV.
module flop_stim_checker #(
    parameter int WIDTH      = 8,
    parameter int COUNT      = 8,
    parameter int RST_CYCLES = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] qout,
    output logic [WIDTH-1:0] qin,
    output logic             duv_reset,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [7:0]       err_count
);

    localparam logic [8:0] COUNT_L = 9'(COUNT);
    localparam logic [8:0] RST_L   = 9'(RST_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_DRIVE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state;
    logic [8:0]       cnt;
    logic [WIDTH-1:0] exp1, exp2;
    logic             vld1, vld2;
    logic             mismatch;

    // Case inequality so that X/Z on qout is flagged in simulation.
    assign mismatch = vld2 && (qout !== exp2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            exp1      <= '0;
            exp2      <= '0;
            vld1      <= 1'b0;
            vld2      <= 1'b0;
            qin       <= '0;
            duv_reset <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
        end else begin
            done <= 1'b0;
            exp2 <= exp1;
            vld2 <= vld1;
            vld1 <= 1'b0;
            exp1 <= '0;
            if (mismatch && err_count != 8'hFF)
                err_count <= err_count + 8'd1;

            case (state)
                S_IDLE: begin
                    qin       <= '0;
                    duv_reset <= 1'b0;
                    busy      <= 1'b0;
                    if (start) begin
                        // First reset cycle pushes no expectation: qout is not yet cleared.
                        state     <= S_RST;
                        duv_reset <= 1'b1;
                        busy      <= 1'b1;
                        cnt       <= 9'd1;
                        err_count <= '0;
                        pass      <= 1'b0;
                    end
                end
                S_RST: begin
                    // Later reset cycles and the first driven value (0) all expect qout == 0.
                    qin  <= '0;
                    vld1 <= 1'b1;
                    if (cnt == RST_L) begin
                        state     <= S_DRIVE;
                        duv_reset <= 1'b0;
                        cnt       <= 9'd1;
                    end else begin
                        cnt <= cnt + 9'd1;
                    end
                end
                S_DRIVE: begin
                    if (cnt == COUNT_L) begin
                        state <= S_DRAIN;
                        qin   <= '0;
                        cnt   <= 9'd1;
                    end else begin
                        qin  <= WIDTH'(cnt);
                        exp1 <= WIDTH'(cnt);
                        vld1 <= 1'b1;
                        cnt  <= cnt + 9'd1;
                    end
                end
                S_DRAIN: begin
                    qin <= '0;
                    if (cnt == 9'd2) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        pass  <= (err_count == 8'd0) && !mismatch;
                    end else begin
                        cnt <= cnt + 9'd1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/flop_stim_checker.md
FLOP_STIM_CHECKER -- requirements
Module: flop_stim_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width of qin/qout.
REQ-002 SHALL have parameter COUNT, default 8, number of data values driven per run (1..256).
REQ-003 SHALL have parameter RST_CYCLES, default 3, cycles the DUV reset is held (1..15).
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 reset  input  1  asynchronous, active-high block reset.
REQ-006 start  input  1  one-cycle request to begin a run; sampled only in IDLE.
REQ-007 qout  input  WIDTH  registered output of the flip-flop under test.
REQ-008 qin  output  WIDTH  data driven to the flip-flop under test.
REQ-009 duv_reset  output  1  synchronous reset driven to the flip-flop under test.
REQ-010 busy  output  1  high from the first cycle after start is accepted until DONE is entered.
REQ-011 done  output  1  one-cycle pulse when a run completes.
REQ-012 pass  output  1  high when the last completed run had zero mismatches; held until the next start.
REQ-013 err_count  output  8  mismatches in the current/last run, saturating at 255.

Function
REQ-014 SHALL implement states IDLE, RST, DRIVE, DRAIN, DONE.
REQ-015 IDLE: qin=0, duv_reset=0, busy=0; start=1 -> RST, clear err_count and pass on the same edge.
REQ-016 RST: duv_reset=1, qin=0, for exactly RST_CYCLES cycles, then -> DRIVE.
REQ-017 DRIVE: qin takes values 0,1,...,COUNT-1 (mod 2^WIDTH) on consecutive cycles, one per cycle, duv_reset=0; after value COUNT-1 is driven -> DRAIN.
REQ-018 All outputs SHALL be registered; a value driven on qin at edge k is captured by the DUV at edge k+1 and SHALL be compared against qout at edge k+2.
REQ-019 Expected values SHALL be held in a 2-deep shift pipeline with per-entry valid bits; comparison occurs only when the stage-2 valid bit is set.
REQ-020 During RST, from the second RST cycle onward, the expected value SHALL be 0 (checks that the DUV reset clears qout); the first RST cycle is not checked.
REQ-021 DRAIN: qin=0, lasts 2 cycles so the final two driven values are checked, then -> DONE.
REQ-022 DONE: done=1 for one cycle, pass=(err_count==0), busy=0, then -> IDLE.
REQ-023 Each mismatch SHALL increment err_count by 1; increment at 255 SHALL leave 255.
REQ-024 start asserted outside IDLE SHALL be ignored (no restart, no counter clear).
REQ-025 start asserted in the DONE cycle SHALL be ignored; start in the following IDLE cycle SHALL be accepted.
REQ-026 Total run length from start acceptance to done pulse SHALL be RST_CYCLES+COUNT+2 cycles in RST/DRIVE/DRAIN plus the DONE cycle.
REQ-027 X/Z on qout SHALL count as a mismatch in simulation (case-inequality compare).

Reset
REQ-028 reset=1 SHALL asynchronously force IDLE, qin=0, duv_reset=0, busy=0, done=0, pass=0, err_count=0, and clear pipeline valid bits.
REQ-029 reset asserted mid-run SHALL abort the run with no done pulse; the next run requires a new start.
REQ-030 Deassertion of reset SHALL take effect on the next posedge clk; no state change occurs on the deassertion edge itself.

Verification
REQ-031 Correct flip-flop, defaults, start pulse -> duv_reset high 3 cycles, qin 0..7, done pulse 13 cycles after acceptance, pass=1, err_count=0.
REQ-032 Flip-flop with qout bit 0 stuck at 1 -> mismatches for expected 0,2,4,6 plus RST checks (2) -> err_count=6, pass=0.
REQ-033 Flip-flop ignoring reset (qout holds 8'hAA before run) -> RST-phase mismatches counted, err_count>=1, pass=0.
REQ-034 start held high continuously for 30 cycles -> exactly two runs, two done pulses, second run begins the cycle after IDLE re-entry.
REQ-035 reset asserted in the 4th DRIVE cycle -> all outputs zero immediately, no done pulse; subsequent start produces a clean full run with pass=1.
REQ-036 COUNT=300 not legal; COUNT=256, WIDTH=8 -> qin wraps 0..255, err_count=0, pass=1.
